// File: rtl/uart_rx_frame_ctrl.sv
// Frame sequencer for the cube-move UART receive path: SOF, LEN, payload, XOR check, drain to executor.
// Optional inter-byte timeout is built when FRAME_TIMEOUT_EN is defined.
module uart_rx_frame_ctrl #(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic       I_sys_clk,
  input  logic       I_rst_n,
  input  logic       I_enable,
  input  logic [7:0] I_rx_data,
  input  logic       I_rx_data_valid,
  output logic       O_baud_enable,
  output logic [7:0] O_move_data,
  output logic       O_move_valid,
  input  logic       I_move_ready,
  output logic       O_frame_done,
  output logic       O_frame_err,
  output logic [1:0] O_err_code,
  output logic       O_overrun
);

  localparam int         PW        = $clog2(MAX_LEN + 1);
  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int         DEPTH     = 1 << AW;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_rx_frame_ctrl: MAX_LEN must be 1..255 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHECK,
    S_DRAIN
  } state_t;

  state_t        state;
  logic [7:0]    frame_buf [DEPTH];
  logic [PW-1:0] len;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_next;
  logic [7:0]    xor_acc;
  logic          rx_byte;
  logic          in_frame;
  logic          timeout_hit;

  // A byte only counts as received while the path is enabled.
  assign rx_byte  = I_rx_data_valid & I_enable;
  assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHECK);
  assign rd_next  = rd_ptr + PW'(1);

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timeout_cnt;

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      timeout_cnt <= '0;
    end else if (!in_frame || rx_byte || !I_enable) begin
      timeout_cnt <= '0;
    end else begin
      timeout_cnt <= timeout_cnt + TW'(1);
    end
  end

  // Fires on the TIMEOUT_CYCLES-th quiet edge after the last byte.
  assign timeout_hit = in_frame && I_enable && !rx_byte &&
                       (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge I_sys_clk) begin
    if (state == S_PAYLOAD && rx_byte) begin
      frame_buf[wr_ptr[AW-1:0]] <= I_rx_data;
    end
  end

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state         <= S_IDLE;
      len           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      xor_acc       <= '0;
      O_baud_enable <= 1'b0;
      O_move_data   <= '0;
      O_move_valid  <= 1'b0;
      O_frame_done  <= 1'b0;
      O_frame_err   <= 1'b0;
      O_err_code    <= '0;
      O_overrun     <= 1'b0;
    end else begin
      O_baud_enable <= I_enable;
      O_frame_done  <= 1'b0;
      O_frame_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_byte && I_rx_data == SOF_BYTE) begin
            state <= S_LEN;
          end
        end
        S_LEN: begin
          if (!I_enable) begin
            state <= S_IDLE;
          end else if (timeout_hit) begin
            O_frame_err <= 1'b1;
            O_err_code  <= 2'd3;
            state       <= S_IDLE;
          end else if (rx_byte) begin
            if (I_rx_data == 8'd0 || I_rx_data > MAX_LEN_B) begin
              O_frame_err <= 1'b1;
              O_err_code  <= 2'd1;
              state       <= S_IDLE;
            end else begin
              len     <= I_rx_data[PW-1:0];
              xor_acc <= I_rx_data;
              wr_ptr  <= '0;
              state   <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (!I_enable) begin
            state <= S_IDLE;
          end else if (timeout_hit) begin
            O_frame_err <= 1'b1;
            O_err_code  <= 2'd3;
            state       <= S_IDLE;
          end else if (rx_byte) begin
            wr_ptr  <= wr_ptr + PW'(1);
            xor_acc <= xor_acc ^ I_rx_data;
            if (wr_ptr + PW'(1) == len) begin
              state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (!I_enable) begin
            state <= S_IDLE;
          end else if (timeout_hit) begin
            O_frame_err <= 1'b1;
            O_err_code  <= 2'd3;
            state       <= S_IDLE;
          end else if (rx_byte) begin
            if (I_rx_data == xor_acc) begin
              rd_ptr       <= '0;
              O_move_data  <= frame_buf[0];
              O_move_valid <= 1'b1;
              state        <= S_DRAIN;
            end else begin
              O_frame_err <= 1'b1;
              O_err_code  <= 2'd2;
              state       <= S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          // Draining ignores I_enable so an accepted frame is always delivered whole.
          if (rx_byte) begin
            O_overrun <= 1'b1;
          end
          if (O_move_valid && I_move_ready) begin
            if (rd_ptr == len - PW'(1)) begin
              O_move_valid <= 1'b0;
              O_frame_done <= 1'b1;
              state        <= S_IDLE;
            end else begin
              rd_ptr      <= rd_next;
              O_move_data <= frame_buf[rd_next[AW-1:0]];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
